// File: rtl/spcpu_alu_decode_unit_pkg.sv
// Shared types and constants for the SPCPU ALU / instruction-decode slice.

package pkg_alu;
    localparam int unsigned ALU_W  = 8;
    localparam int unsigned PAIR_W = 2 * ALU_W;
    localparam int unsigned OPER_W = 5;

    typedef enum logic [OPER_W-1:0] {
        alu_add   = 5'd0,
        alu_adc   = 5'd1,
        alu_sub   = 5'd2,
        alu_sbc   = 5'd3,
        alu_cmp   = 5'd4,
        alu_and   = 5'd5,
        alu_orr   = 5'd6,
        alu_xor   = 5'd7,
        alu_inv   = 5'd8,
        alu_invp  = 5'd9,
        alu_neg   = 5'd10,
        alu_negp  = 5'd11,
        alu_lsl   = 5'd12,
        alu_lsr   = 5'd13,
        alu_asr   = 5'd14,
        alu_rol   = 5'd15,
        alu_ror   = 5'd16,
        alu_rolc  = 5'd17,
        alu_rorc  = 5'd18,
        alu_lslp  = 5'd19,
        alu_lsrp  = 5'd20,
        alu_asrp  = 5'd21,
        alu_rolp  = 5'd22,
        alu_rorp  = 5'd23,
        alu_rolcp = 5'd24,
        alu_rorcp = 5'd25
    } alu_oper;

    typedef enum logic [1:0] {
        cat_8_no_ci  = 2'd0,
        cat_8_ci     = 2'd1,
        cat_16_no_ci = 2'd2,
        cat_16_ci    = 2'd3
    } alu_oper_cat;

    // Operand width and carry-in dependence of an operation; illegal codes fall to 8_no_ci.
    function automatic alu_oper_cat get_alu_oper_cat(input logic [OPER_W-1:0] oper);
        alu_oper_cat cat;
        cat = cat_8_no_ci;
        case (oper)
            alu_adc, alu_sbc, alu_rolc, alu_rorc:         cat = cat_8_ci;
            alu_rolcp, alu_rorcp:                         cat = cat_16_ci;
            alu_invp, alu_negp, alu_lslp, alu_lsrp,
            alu_asrp, alu_rolp, alu_rorp:                 cat = cat_16_no_ci;
            default:                                      cat = cat_8_no_ci;
        endcase
        return cat;
    endfunction
endpackage

package pkg_pflags;
    localparam int unsigned PFLAGS_W  = 4;
    localparam int unsigned pf_slot_z = 3;
    localparam int unsigned pf_slot_c = 2;
    localparam int unsigned pf_slot_v = 1;
    localparam int unsigned pf_slot_n = 0;
endpackage

package pkg_instr_dec;
    localparam int unsigned INSTR_W       = 16;
    localparam int unsigned GROUP_ID_W    = 3;
    localparam int unsigned G1_OPCODE_MSB = 14;
    localparam int unsigned G1_OPCODE_W   = 3;
    localparam int unsigned G1_RA_MSB     = 11;
    localparam int unsigned G1_RA_W       = 4;
    localparam int unsigned G1_IMM_MSB    = 7;
    localparam int unsigned G1_IMM_W      = 8;

    localparam logic [GROUP_ID_W-1:0] GROUP_ID_GRP2 = 3'b100;
    localparam logic [GROUP_ID_W-1:0] GROUP_ID_GRP3 = 3'b101;

    typedef enum logic [1:0] {
        grp_1       = 2'd0,
        grp_2       = 2'd1,
        grp_3       = 2'd2,
        grp_unknown = 2'd3
    } instr_group;

    typedef enum logic [G1_OPCODE_W-1:0] {
        g1_addi = 3'd0,
        g1_adci = 3'd1,
        g1_subi = 3'd2,
        g1_sbci = 3'd3,
        g1_cmpi = 3'd4,
        g1_andi = 3'd5,
        g1_orri = 3'd6,
        g1_cpyi = 3'd7
    } g1_opcode;

    // Group classification from the top bits of the high instruction word.
    function automatic instr_group decode_group(input logic [INSTR_W-1:0] instr);
        instr_group grp;
        if (!instr[INSTR_W-1])
            grp = grp_1;
        else if (instr[INSTR_W-1 -: GROUP_ID_W] == GROUP_ID_GRP2)
            grp = grp_2;
        else if (instr[INSTR_W-1 -: GROUP_ID_W] == GROUP_ID_GRP3)
            grp = grp_3;
        else
            grp = grp_unknown;
        return grp;
    endfunction
endpackage

// File: rtl/spcpu_alu_decode_unit_core.sv
// Purely combinational 8/16-bit ALU with processor-flags update.

module spcpu_alu_core
    import pkg_alu::*;
    import pkg_pflags::*;
(
    input  logic [OPER_W-1:0]   i_oper,
    input  logic [ALU_W-1:0]    i_a_hi,
    input  logic [ALU_W-1:0]    i_a_lo,
    input  logic [ALU_W-1:0]    i_b,
    input  logic [PFLAGS_W-1:0] i_flags,
    output logic [ALU_W-1:0]    o_res_hi_c,
    output logic [ALU_W-1:0]    o_res_lo_c,
    output logic [PFLAGS_W-1:0] o_flags_c
);

    logic [PAIR_W-1:0] w_a16;
    logic              w_ci;
    logic              w_vi;
    logic [ALU_W:0]    w_add;
    logic [ALU_W:0]    w_sub;
    logic [ALU_W:0]    w_lsl8;
    logic [ALU_W:0]    w_lsr8;
    logic [ALU_W:0]    w_asr8;
    logic [PAIR_W:0]   w_lsl16;
    logic [PAIR_W:0]   w_lsr16;
    logic [PAIR_W:0]   w_asr16;
    logic [2:0]        w_r8;
    logic [3:0]        w_r16;
    logic [ALU_W-1:0]  w_rol8;
    logic [ALU_W-1:0]  w_ror8;
    logic [PAIR_W-1:0] w_rol16;
    logic [PAIR_W-1:0] w_ror16;
    logic              w_big8;
    logic              w_big16;
    logic              w_cnt0;

    logic [ALU_W-1:0]  w_res8;
    logic [PAIR_W-1:0] w_res16;
    logic              w_pair;
    logic              w_cmp;
    logic              w_legal;
    logic              w_c;
    logic              w_v;

    assign w_a16 = {i_a_hi, i_a_lo};
    assign w_ci  = i_flags[pf_slot_c];
    assign w_vi  = i_flags[pf_slot_v];

    // Adders: adc folds in C, sub adds the implicit +1, sbc uses C as the not-borrow input.
    assign w_add = {1'b0, i_a_lo} + {1'b0, i_b}
                 + (ALU_W+1)'((i_oper == alu_adc) ? w_ci : 1'b0);
    assign w_sub = {1'b0, i_a_lo} + {1'b0, ~i_b}
                 + (ALU_W+1)'((i_oper == alu_sbc) ? w_ci : 1'b1);

    // Shifters carry one spare bit so the last bit shifted out lands in a known position.
    assign w_lsl8  = {1'b0, i_a_lo} << i_b;
    assign w_lsr8  = {i_a_lo, 1'b0} >> i_b;
    assign w_asr8  = (ALU_W+1)'($signed({i_a_lo, 1'b0}) >>> i_b);
    assign w_lsl16 = {1'b0, w_a16} << i_b;
    assign w_lsr16 = {w_a16, 1'b0} >> i_b;
    assign w_asr16 = (PAIR_W+1)'($signed({w_a16, 1'b0}) >>> i_b);
    assign w_cnt0  = (i_b == '0);
    assign w_big8  = (i_b >= 8'(ALU_W));
    assign w_big16 = (i_b >= 8'(PAIR_W));

    // Rotators: count reduced modulo width; a zero count yields A unchanged.
    assign w_r8    = i_b[2:0];
    assign w_r16   = i_b[3:0];
    assign w_rol8  = (i_a_lo << w_r8)  | (i_a_lo >> (4'(ALU_W)  - {1'b0, w_r8}));
    assign w_ror8  = (i_a_lo >> w_r8)  | (i_a_lo << (4'(ALU_W)  - {1'b0, w_r8}));
    assign w_rol16 = (w_a16  << w_r16) | (w_a16  >> (5'(PAIR_W) - {1'b0, w_r16}));
    assign w_ror16 = (w_a16  >> w_r16) | (w_a16  << (5'(PAIR_W) - {1'b0, w_r16}));

    // Operation select: result, width, carry and overflow per operation.
    always_comb begin
        w_res8  = i_a_lo;
        w_res16 = w_a16;
        w_pair  = 1'b0;
        w_cmp   = 1'b0;
        w_legal = 1'b1;
        w_c     = w_ci;
        w_v     = w_vi;
        case (alu_oper'(i_oper))
            alu_add, alu_adc: begin
                w_res8 = w_add[ALU_W-1:0];
                w_c    = w_add[ALU_W];
                w_v    = (i_a_lo[ALU_W-1] == i_b[ALU_W-1]) &&
                         (w_add[ALU_W-1] != i_a_lo[ALU_W-1]);
            end
            alu_sub, alu_sbc, alu_cmp: begin
                w_res8 = w_sub[ALU_W-1:0];
                w_c    = w_sub[ALU_W];
                w_v    = (i_a_lo[ALU_W-1] != i_b[ALU_W-1]) &&
                         (w_sub[ALU_W-1] != i_a_lo[ALU_W-1]);
                w_cmp  = (i_oper == alu_cmp);
            end
            alu_and: w_res8 = i_a_lo & i_b;
            alu_orr: w_res8 = i_a_lo | i_b;
            alu_xor: w_res8 = i_a_lo ^ i_b;
            alu_inv: w_res8 = ~i_a_lo;
            alu_invp: begin
                w_pair  = 1'b1;
                w_res16 = ~w_a16;
            end
            alu_neg: begin
                w_res8 = -i_a_lo;
                w_c    = (i_a_lo == '0);
                w_v    = (i_a_lo == {1'b1, {(ALU_W-1){1'b0}}});
            end
            alu_negp: begin
                w_pair  = 1'b1;
                w_res16 = -w_a16;
                w_c     = (w_a16 == '0);
                w_v     = (w_a16 == {1'b1, {(PAIR_W-1){1'b0}}});
            end
            alu_lsl: begin
                if (w_big8) begin
                    w_res8 = '0;
                    w_c    = 1'b0;
                end else if (!w_cnt0) begin
                    w_res8 = w_lsl8[ALU_W-1:0];
                    w_c    = w_lsl8[ALU_W];
                end
            end
            alu_lsr: begin
                if (w_big8) begin
                    w_res8 = '0;
                    w_c    = 1'b0;
                end else if (!w_cnt0) begin
                    w_res8 = w_lsr8[ALU_W:1];
                    w_c    = w_lsr8[0];
                end
            end
            alu_asr: begin
                if (w_big8) begin
                    w_res8 = {ALU_W{i_a_lo[ALU_W-1]}};
                    w_c    = i_a_lo[ALU_W-1];
                end else if (!w_cnt0) begin
                    w_res8 = w_asr8[ALU_W:1];
                    w_c    = w_asr8[0];
                end
            end
            alu_rol: begin
                w_res8 = w_rol8;
                if (w_r8 != '0) w_c = w_rol8[0];
            end
            alu_ror: begin
                w_res8 = w_ror8;
                if (w_r8 != '0) w_c = w_ror8[ALU_W-1];
            end
            alu_rolc: begin
                w_res8 = {i_a_lo[ALU_W-2:0], w_ci};
                w_c    = i_a_lo[ALU_W-1];
            end
            alu_rorc: begin
                w_res8 = {w_ci, i_a_lo[ALU_W-1:1]};
                w_c    = i_a_lo[0];
            end
            alu_lslp: begin
                w_pair = 1'b1;
                if (w_big16) begin
                    w_res16 = '0;
                    w_c     = 1'b0;
                end else if (!w_cnt0) begin
                    w_res16 = w_lsl16[PAIR_W-1:0];
                    w_c     = w_lsl16[PAIR_W];
                end
            end
            alu_lsrp: begin
                w_pair = 1'b1;
                if (w_big16) begin
                    w_res16 = '0;
                    w_c     = 1'b0;
                end else if (!w_cnt0) begin
                    w_res16 = w_lsr16[PAIR_W:1];
                    w_c     = w_lsr16[0];
                end
            end
            alu_asrp: begin
                w_pair = 1'b1;
                if (w_big16) begin
                    w_res16 = {PAIR_W{w_a16[PAIR_W-1]}};
                    w_c     = w_a16[PAIR_W-1];
                end else if (!w_cnt0) begin
                    w_res16 = w_asr16[PAIR_W:1];
                    w_c     = w_asr16[0];
                end
            end
            alu_rolp: begin
                w_pair  = 1'b1;
                w_res16 = w_rol16;
                if (w_r16 != '0) w_c = w_rol16[0];
            end
            alu_rorp: begin
                w_pair  = 1'b1;
                w_res16 = w_ror16;
                if (w_r16 != '0) w_c = w_ror16[PAIR_W-1];
            end
            alu_rolcp: begin
                w_pair  = 1'b1;
                w_res16 = {w_a16[PAIR_W-2:0], w_ci};
                w_c     = w_a16[PAIR_W-1];
            end
            alu_rorcp: begin
                w_pair  = 1'b1;
                w_res16 = {w_ci, w_a16[PAIR_W-1:1]};
                w_c     = w_a16[0];
            end
            default: w_legal = 1'b0;
        endcase
    end

    // Result routing and flag assembly; illegal codes pass A and the incoming flags through.
    always_comb begin
        o_res_hi_c = i_a_hi;
        o_res_lo_c = w_cmp ? i_a_lo : w_res8;
        o_flags_c  = i_flags;
        if (w_pair) begin
            o_res_hi_c = w_res16[PAIR_W-1:ALU_W];
            o_res_lo_c = w_res16[ALU_W-1:0];
        end
        if (w_legal) begin
            o_flags_c[pf_slot_z] = w_pair ? (w_res16 == '0) : (w_res8 == '0);
            o_flags_c[pf_slot_n] = w_pair ? w_res16[PAIR_W-1] : w_res8[ALU_W-1];
            o_flags_c[pf_slot_c] = w_c;
            o_flags_c[pf_slot_v] = w_v;
        end
    end

endmodule

// File: rtl/spcpu_alu_decode_unit.sv
// Execute front end: instruction group/field decode plus one ALU op per cycle, all outputs registered.

module spcpu_alu_decode_unit
    import pkg_alu::*;
    import pkg_pflags::*;
    import pkg_instr_dec::*;
(
    input  logic                   clk,
    input  logic                   reset,
    input  logic [INSTR_W-1:0]     instr_hi,
    input  logic [OPER_W-1:0]      oper,
    input  logic [ALU_W-1:0]       a_in_hi,
    input  logic [ALU_W-1:0]       a_in_lo,
    input  logic [ALU_W-1:0]       b_in,
    input  logic [PFLAGS_W-1:0]    proc_flags_in,
    output logic [1:0]             group_out,
    output logic [G1_OPCODE_W-1:0] g1_opcode_out,
    output logic [G1_RA_W-1:0]     g1_ra_index_out,
    output logic [G1_IMM_W-1:0]    g1_imm8_out,
    output logic [1:0]             oper_cat_out,
    output logic [ALU_W-1:0]       out_hi,
    output logic [ALU_W-1:0]       out_lo,
    output logic [PFLAGS_W-1:0]    proc_flags_out
);

    logic [ALU_W-1:0]       w_res_hi;
    logic [ALU_W-1:0]       w_res_lo;
    logic [PFLAGS_W-1:0]    w_flags;
    instr_group             w_group;
    alu_oper_cat            w_cat;

    instr_group             r_group;
    g1_opcode               r_g1_opcode;
    logic [G1_RA_W-1:0]     r_g1_ra;
    logic [G1_IMM_W-1:0]    r_g1_imm;
    alu_oper_cat            r_cat;
    logic [ALU_W-1:0]       r_out_hi;
    logic [ALU_W-1:0]       r_out_lo;
    logic [PFLAGS_W-1:0]    r_flags;

    spcpu_alu_core u_core (
        .i_oper     (oper),
        .i_a_hi     (a_in_hi),
        .i_a_lo     (a_in_lo),
        .i_b        (b_in),
        .i_flags    (proc_flags_in),
        .o_res_hi_c (w_res_hi),
        .o_res_lo_c (w_res_lo),
        .o_flags_c  (w_flags)
    );

    assign w_group = decode_group(instr_hi);
    assign w_cat   = get_alu_oper_cat(oper);

    // Output registers; group-1 fields are taken from the raw word whatever the group.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_group     <= grp_unknown;
            r_g1_opcode <= g1_addi;
            r_g1_ra     <= '0;
            r_g1_imm    <= '0;
            r_cat       <= cat_8_no_ci;
            r_out_hi    <= '0;
            r_out_lo    <= '0;
            r_flags     <= '0;
        end else begin
            r_group     <= w_group;
            r_g1_opcode <= g1_opcode'(instr_hi[G1_OPCODE_MSB -: G1_OPCODE_W]);
            r_g1_ra     <= instr_hi[G1_RA_MSB -: G1_RA_W];
            r_g1_imm    <= instr_hi[G1_IMM_MSB -: G1_IMM_W];
            r_cat       <= w_cat;
            r_out_hi    <= w_res_hi;
            r_out_lo    <= w_res_lo;
            r_flags     <= w_flags;
        end
    end

    assign group_out       = r_group;
    assign g1_opcode_out   = r_g1_opcode;
    assign g1_ra_index_out = r_g1_ra;
    assign g1_imm8_out     = r_g1_imm;
    assign oper_cat_out    = r_cat;
    assign out_hi          = r_out_hi;
    assign out_lo          = r_out_lo;
    assign proc_flags_out  = r_flags;

endmodule

// File: tb/tb_spcpu_alu_decode_unit.sv
// Directed scoreboard bench for spcpu_alu_decode_unit; flags written as {Z,C,V,N}.

module tb_spcpu_alu_decode_unit;

    localparam logic [4:0] OP_ADD = 5'd0,  OP_ADC = 5'd1,  OP_SUB = 5'd2,  OP_SBC = 5'd3;
    localparam logic [4:0] OP_CMP = 5'd4,  OP_AND = 5'd5,  OP_ORR = 5'd6,  OP_XOR = 5'd7;
    localparam logic [4:0] OP_INVP = 5'd9, OP_NEG = 5'd10, OP_NEGP = 5'd11;
    localparam logic [4:0] OP_LSL = 5'd12, OP_ASR = 5'd14, OP_ROL = 5'd15, OP_ROR = 5'd16;
    localparam logic [4:0] OP_ROLC = 5'd17, OP_LSRP = 5'd20, OP_RORP = 5'd23, OP_ROLCP = 5'd24;
    localparam logic [4:0] OP_ILL = 5'd27;

    typedef struct {
        logic [1:0] grp;
        logic [2:0] op;
        logic [3:0] ra;
        logic [7:0] imm;
        logic [1:0] cat;
        logic [7:0] hi;
        logic [7:0] lo;
        logic [3:0] fl;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] instr_hi;
    logic [4:0]  oper;
    logic [7:0]  a_in_hi, a_in_lo, b_in;
    logic [3:0]  proc_flags_in;
    logic [1:0]  group_out;
    logic [2:0]  g1_opcode_out;
    logic [3:0]  g1_ra_index_out;
    logic [7:0]  g1_imm8_out;
    logic [1:0]  oper_cat_out;
    logic [7:0]  out_hi, out_lo;
    logic [3:0]  proc_flags_out;

    exp_t sb_q[$];
    int   n_vec = 0;
    int   n_err = 0;

    spcpu_alu_decode_unit dut (
        .clk             (clk),
        .reset           (reset),
        .instr_hi        (instr_hi),
        .oper            (oper),
        .a_in_hi         (a_in_hi),
        .a_in_lo         (a_in_lo),
        .b_in            (b_in),
        .proc_flags_in   (proc_flags_in),
        .group_out       (group_out),
        .g1_opcode_out   (g1_opcode_out),
        .g1_ra_index_out (g1_ra_index_out),
        .g1_imm8_out     (g1_imm8_out),
        .oper_cat_out    (oper_cat_out),
        .out_hi          (out_hi),
        .out_lo          (out_lo),
        .proc_flags_out  (proc_flags_out)
    );

    always #5 clk = ~clk;

    initial begin
        #1ms;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] ref_group(input logic [15:0] w);
        logic [2:0] top;
        top = w[15:13];
        if (!top[2])          return 2'd0;
        else if (top == 3'b100) return 2'd1;
        else if (top == 3'b101) return 2'd2;
        else                  return 2'd3;
    endfunction

    function automatic logic [1:0] ref_cat(input logic [4:0] op);
        if (op == 5'd1 || op == 5'd3 || op == 5'd17 || op == 5'd18) return 2'd1;
        if (op == 5'd24 || op == 5'd25)                             return 2'd3;
        if (op == 5'd9 || op == 5'd11 || (op >= 5'd19 && op <= 5'd23)) return 2'd2;
        return 2'd0;
    endfunction

    task automatic compare_out(input string name);
        exp_t e;
        if (sb_q.size() == 0) begin
            n_vec++;
            n_err++;
            $error("FAIL %s: observed=empty-scoreboard expected=entry", name);
            return;
        end
        e = sb_q.pop_front();
        chk({name, ".group"}, 16'(group_out),       16'(e.grp));
        chk({name, ".g1op"},  16'(g1_opcode_out),   16'(e.op));
        chk({name, ".g1ra"},  16'(g1_ra_index_out), 16'(e.ra));
        chk({name, ".imm8"},  16'(g1_imm8_out),     16'(e.imm));
        chk({name, ".cat"},   16'(oper_cat_out),    16'(e.cat));
        chk({name, ".out"},   {out_hi, out_lo},     {e.hi, e.lo});
        chk({name, ".flags"}, 16'(proc_flags_out),  16'(e.fl));
    endtask

    // Drive one vector, record its expectation, then compare once the DUT has registered it.
    task automatic step(input string name, input logic [15:0] ins, input logic [4:0] op,
                        input logic [7:0] ahi, input logic [7:0] alo, input logic [7:0] b,
                        input logic [3:0] fin, input logic [7:0] ehi, input logic [7:0] elo,
                        input logic [3:0] efl);
        exp_t e;
        instr_hi      = ins;
        oper          = op;
        a_in_hi       = ahi;
        a_in_lo       = alo;
        b_in          = b;
        proc_flags_in = fin;
        e.grp = ref_group(ins);
        e.op  = ins[14:12];
        e.ra  = ins[11:8];
        e.imm = ins[7:0];
        e.cat = ref_cat(op);
        e.hi  = ehi;
        e.lo  = elo;
        e.fl  = efl;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        compare_out(name);
    endtask

    initial begin
        // Reset held two cycles with busy inputs: reset must win over the load path.
        reset         = 1'b1;
        instr_hi      = 16'h1733;
        oper          = OP_ADC;
        a_in_hi       = 8'hAA;
        a_in_lo       = 8'h55;
        b_in          = 8'h0F;
        proc_flags_in = 4'hF;
        repeat (2) @(posedge clk);
        #1;
        chk("rst.group", 16'(group_out),       16'd3);
        chk("rst.g1op",  16'(g1_opcode_out),   16'd0);
        chk("rst.g1ra",  16'(g1_ra_index_out), 16'd0);
        chk("rst.imm8",  16'(g1_imm8_out),     16'd0);
        chk("rst.cat",   16'(oper_cat_out),    16'd0);
        chk("rst.out",   {out_hi, out_lo},     16'h0000);
        chk("rst.flags", 16'(proc_flags_out),  16'd0);
        reset = 1'b0;

        //    name        instr     op        ahi    alo    b      fin      ehi    elo    {Z,C,V,N}
        step("add",      16'h1733, OP_ADD,   8'h00, 8'h33, 8'h01, 4'b0000, 8'h00, 8'h34, 4'b0000);
        step("add_ovf",  16'h4199, OP_ADD,   8'h12, 8'h7F, 8'h01, 4'b0000, 8'h12, 8'h80, 4'b0011);
        step("sub_eq",   16'h8039, OP_SUB,   8'h00, 8'h05, 8'h05, 4'b0000, 8'h00, 8'h00, 4'b1100);
        step("sbc_brw",  16'hA4D7, OP_SBC,   8'h00, 8'h00, 8'h00, 4'b0000, 8'h00, 8'hFF, 4'b0001);
        step("lsl1",     16'hE000, OP_LSL,   8'h00, 8'h81, 8'h01, 4'b0000, 8'h00, 8'h02, 4'b0100);
        step("ror9",     16'h7F01, OP_ROR,   8'h00, 8'h01, 8'h09, 4'b0000, 8'h00, 8'h80, 4'b0101);
        step("rolcp",    16'hC123, OP_ROLCP, 8'h80, 8'h00, 8'h00, 4'b0000, 8'h00, 8'h00, 4'b1100);
        step("cmp",      16'h2A5C, OP_CMP,   8'h55, 8'h10, 8'h20, 4'b0000, 8'h55, 8'h10, 4'b0001);
        step("lsl_big",  16'hBFFF, OP_LSL,   8'h00, 8'hFF, 8'h08, 4'b0110, 8'h00, 8'h00, 4'b1010);
        step("lsl0",     16'h0000, OP_LSL,   8'h00, 8'h5A, 8'h00, 4'b0100, 8'h00, 8'h5A, 4'b0100);
        step("asr2",     16'h9000, OP_ASR,   8'h00, 8'h84, 8'h02, 4'b0000, 8'h00, 8'hE1, 4'b0001);
        step("asr_big",  16'h3C3C, OP_ASR,   8'h00, 8'h84, 8'h14, 4'b0000, 8'h00, 8'hFF, 4'b0101);
        step("adc_ci",   16'h5E11, OP_ADC,   8'h00, 8'hFF, 8'h00, 4'b0100, 8'h00, 8'h00, 4'b1100);
        step("neg_min",  16'h6001, OP_NEG,   8'h00, 8'h80, 8'h00, 4'b0000, 8'h00, 8'h80, 4'b0011);
        step("negp0",    16'hF00F, OP_NEGP,  8'h00, 8'h00, 8'h00, 4'b0000, 8'h00, 8'h00, 4'b1100);
        step("lsrp1",    16'h0102, OP_LSRP,  8'h80, 8'h01, 8'h01, 4'b0000, 8'h40, 8'h00, 4'b0100);
        step("rorp17",   16'hA000, OP_RORP,  8'h00, 8'h01, 8'h11, 4'b0000, 8'h80, 8'h00, 4'b0101);
        step("and_zero", 16'h5555, OP_AND,   8'h00, 8'hF0, 8'h0F, 4'b0110, 8'h00, 8'h00, 4'b1110);
        step("xor",      16'h8888, OP_XOR,   8'h00, 8'hAA, 8'hFF, 4'b0000, 8'h00, 8'h55, 4'b0000);
        step("illegal",  16'hDEAD, OP_ILL,   8'h12, 8'h34, 8'h56, 4'b1010, 8'h12, 8'h34, 4'b1010);
        step("rolc",     16'h3210, OP_ROLC,  8'h00, 8'h80, 8'h00, 4'b0000, 8'h00, 8'h00, 4'b1100);
        step("invp",     16'h4444, OP_INVP,  8'h00, 8'hFF, 8'h00, 4'b0110, 8'hFF, 8'h00, 4'b0111);
        step("rol_mod8", 16'h0F0F, OP_ROL,   8'h00, 8'h81, 8'h08, 4'b0000, 8'h00, 8'h81, 4'b0001);
        step("orr_zero", 16'hB000, OP_ORR,   8'h00, 8'h00, 8'h00, 4'b0001, 8'h00, 8'h00, 4'b1000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
